// File: rtl/board_io_pkg.sv
// Shared constants for the board input peripheral: register offsets within its
// window and the window base used by the board-level address decode.
package board_io_pkg;

   localparam logic [3:0]  IO_SW   = 4'h0;
   localparam logic [3:0]  IO_BTN  = 4'h4;
   localparam logic [3:0]  IO_EVT  = 4'h8;
   localparam logic [3:0]  IO_CNT  = 4'hC;

   localparam logic [31:0] IO_BASE = 32'h1002_0000;

   localparam int          CNT_W   = 16;

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchronizer followed by a stability counter; the stable output only
// follows the synced input after DEBOUNCE_CYCLES consecutive mismatching cycles.
module debounce_cell #(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic        sync1;
   logic        sync2;
   logic [15:0] cnt;
   logic        settle;

   // settle is the edge on which stable takes the synced value; rise is exposed
   // combinationally so the event latch updates on that very same edge.
   assign settle = (sync2 != stable) && (cnt == LAST);
   assign rise   = settle && sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if ((sync2 == stable) || settle)
            cnt <= '0;
         else
            cnt <= cnt + 16'd1;
         if (settle)
            stable <= sync2;
      end
   end

endmodule

// File: rtl/board_input_port.sv
// Memory-mapped switch/button input port: debounced levels, sticky press events
// with W1C clear, a 16-bit press counter and an event interrupt.
module board_input_port #(
   parameter int N_SW            = 16,
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              WR,
   input  logic [3:0]        addr,
   input  logic [31:0]       datain_32,
   input  logic [N_SW-1:0]   sw_in,
   input  logic [N_BTN-1:0]  btn_in,
   output logic [31:0]       dataout_32,
   output logic              irq
);

   import board_io_pkg::*;

   logic [N_SW-1:0]  sw_stable;
   logic [N_SW-1:0]  sw_rise;
   logic [N_BTN-1:0] btn_stable;
   logic [N_BTN-1:0] btn_rise;

   logic [N_BTN-1:0] evt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] rise_cnt;
   logic [N_BTN-1:0] evt_clr;
   logic [CNT_W-1:0] cnt_base;

   logic             rd;
   logic             wr_evt;
   logic             wr_cnt;
   logic [3:0]       reg_sel;
   logic             unused_ok;

   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .rst    (rst),
         .raw    (sw_in[i]),
         .stable (sw_stable[i]),
         .rise   (sw_rise[i])
      );
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .rst    (rst),
         .raw    (btn_in[i]),
         .stable (btn_stable[i]),
         .rise   (btn_rise[i])
      );
   end

   assign reg_sel = {addr[3:2], 2'b00};
   assign rd      = ena && !WR;
   assign wr_evt  = ena && WR && (reg_sel == IO_EVT);
   assign wr_cnt  = ena && WR && (reg_sel == IO_CNT);

   always_comb begin
      rise_cnt = '0;
      for (int i = 0; i < N_BTN; i++)
         rise_cnt = rise_cnt + CNT_W'(btn_rise[i]);
   end

   // A new press wins over a same-cycle clear; a CNT write is the base the
   // same-cycle presses are added to.
   assign evt_clr  = wr_evt ? datain_32[N_BTN-1:0] : '0;
   assign cnt_base = wr_cnt ? datain_32[CNT_W-1:0] : cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt <= '0;
         cnt <= '0;
      end else begin
         evt <= (evt & ~evt_clr) | btn_rise;
         cnt <= cnt_base + rise_cnt;
      end
   end

   assign irq = |evt;

   always_comb begin
      dataout_32 = '0;
      if (rd) begin
         case (reg_sel)
            IO_SW:   dataout_32 = 32'(sw_stable);
            IO_BTN:  dataout_32 = 32'(btn_stable);
            IO_EVT:  dataout_32 = 32'(evt);
            IO_CNT:  dataout_32 = 32'(cnt);
            default: dataout_32 = '0;
         endcase
      end
   end

   assign unused_ok = ^{datain_32[31:CNT_W], addr[1:0], sw_rise};

endmodule
